// File: rtl/order_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module : order_dispatcher_if
// Brief  : Message and book-side signal bundle for order_dispatcher.
//          slave  = the dispatcher, master = feed parser + books side.
// Rev    : 1.0  initial release
// ============================================================================

`ifndef ORDER_INDEX
`define ORDER_INDEX 7
`endif
`ifndef QUANTITY_INDEX
`define QUANTITY_INDEX 15
`endif
`ifndef TOTAL_BITS
`define TOTAL_BITS 40
`endif
`ifndef ADD_ORDER
`define ADD_ORDER 3'b001
`endif
`ifndef CANCEL_ORDER
`define CANCEL_ORDER 3'b010
`endif
`ifndef EXECUTE_ORDER
`define EXECUTE_ORDER 3'b011
`endif

interface order_dispatcher_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  // parser -> dispatcher
  logic                       msg_valid;
  logic                       msg_ready;
  logic                       msg_side;
  logic [2:0]                 msg_request;
  logic [`TOTAL_BITS-1:0]     msg_order;
  logic [`ORDER_INDEX:0]      msg_id;
  logic [`QUANTITY_INDEX:0]   msg_qty;

  // dispatcher <-> books
  logic                       buy_start;
  logic                       sell_start;
  logic [2:0]                 book_request;
  logic [`TOTAL_BITS-1:0]     book_order;
  logic [`ORDER_INDEX:0]      book_id;
  logic [`QUANTITY_INDEX:0]   book_qty;
  logic                       buy_busy;
  logic                       sell_busy;

  // status
  logic                       done;
  logic                       done_side;
  logic                       err_invalid;
  logic                       err_timeout;
  logic [COUNT_W-1:0]         fifo_count;

  modport slave (
    input  msg_valid, msg_side, msg_request, msg_order, msg_id, msg_qty,
    input  buy_busy, sell_busy,
    output msg_ready,
    output buy_start, sell_start, book_request, book_order, book_id, book_qty,
    output done, done_side, err_invalid, err_timeout, fifo_count
  );

  modport master (
    output msg_valid, msg_side, msg_request, msg_order, msg_id, msg_qty,
    output buy_busy, sell_busy,
    input  msg_ready,
    input  buy_start, sell_start, book_request, book_order, book_id, book_qty,
    input  done, done_side, err_invalid, err_timeout, fifo_count
  );
endinterface

`default_nettype wire

// File: rtl/order_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : order_dispatcher
// Brief  : Buffers parsed order messages in a FIFO and issues them one at a
//          time to the buy or sell order_book, tracking the book's is_busy
//          handshake. Optional macro DISPATCH_TIMEOUT_EN adds a watchdog on
//          the busy phase.
// Rev    : 1.0  initial release
// ============================================================================

`ifndef ORDER_INDEX
`define ORDER_INDEX 7
`endif
`ifndef QUANTITY_INDEX
`define QUANTITY_INDEX 15
`endif
`ifndef TOTAL_BITS
`define TOTAL_BITS 40
`endif
`ifndef ADD_ORDER
`define ADD_ORDER 3'b001
`endif
`ifndef CANCEL_ORDER
`define CANCEL_ORDER 3'b010
`endif
`ifndef EXECUTE_ORDER
`define EXECUTE_ORDER 3'b011
`endif

module order_dispatcher #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ACK_TIMEOUT  = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input wire clk_in,
  input wire rst_in,
  order_dispatcher_if.slave bus
);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = ADDR_W + 1;
  localparam int ORDER_W = `TOTAL_BITS;
  localparam int ID_W    = `ORDER_INDEX + 1;
  localparam int QTY_W   = `QUANTITY_INDEX + 1;
  localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic               side;
    logic [2:0]         request;
    logic [ORDER_W-1:0] order;
    logic [ID_W-1:0]    id;
    logic [QTY_W-1:0]   qty;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Message FIFO
  // --------------------------------------------------------------------------
  entry_t              mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0]  count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  entry_t              head;

  assign full          = (count == COUNT_W'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign head          = mem[rd_ptr];
  // Held low during reset so the parser cannot push into a FIFO being cleared.
  assign bus.msg_ready = rst_in & ~full;
  assign push          = bus.msg_valid & bus.msg_ready;

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= '{side:    bus.msg_side,
                       request: bus.msg_request,
                       order:   bus.msg_order,
                       id:      bus.msg_id,
                       qty:     bus.msg_qty};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch FSM
  // --------------------------------------------------------------------------
  state_t              state;
  state_t              state_nxt;
  logic                cur_side;
  logic [ACK_W-1:0]    ack_cnt;
  logic                load;
  logic                err_inv;
  logic                err_to;
  logic                head_valid;
  logic                head_busy;
  logic                head_blocked;
  logic                target_busy;
  logic [2:0]          req_q;
  logic [ORDER_W-1:0]  order_q;
  logic [ID_W-1:0]     id_q;
  logic [QTY_W-1:0]    qty_q;

  assign head_valid  = head.request inside {`ADD_ORDER, `CANCEL_ORDER, `EXECUTE_ORDER};
  assign head_busy   = head.side ? bus.sell_busy : bus.buy_busy;
  assign target_busy = cur_side  ? bus.sell_busy : bus.buy_busy;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);
  logic [BUSY_W-1:0]   busy_cnt;
  logic [1:0]          hold_off;
  logic                abort;

  // A side that was abandoned mid-operation stays blocked until its busy drops.
  assign head_blocked = head_busy | hold_off[head.side];
`else
  // BUSY_TIMEOUT only matters when the busy-phase watchdog is built in.
  logic unused_busy_timeout;
  assign unused_busy_timeout = ^BUSY_TIMEOUT;
  assign head_blocked        = head_busy;
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic plus the pop/load/error strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    err_inv   = 1'b0;
    err_to    = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!head_valid) begin
            pop     = 1'b1;
            err_inv = 1'b1;
          end else if (!head_blocked) begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (target_busy) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          err_to    = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!target_busy) begin
          state_nxt = DONE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (busy_cnt == BUSY_W'(BUSY_TIMEOUT - 1)) begin
          err_to    = 1'b1;
          abort     = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts consecutive WAIT_ACK cycles without an acknowledge from the book.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                ack_cnt <= '0;
    else if (state == WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
    else                        ack_cnt <= '0;
  end

`ifdef DISPATCH_TIMEOUT_EN
  // Counts cycles spent in WAIT_DONE for the busy-phase watchdog.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                 busy_cnt <= '0;
    else if (state == WAIT_DONE) busy_cnt <= busy_cnt + 1'b1;
    else                         busy_cnt <= '0;
  end

  // Tracks sides abandoned by the watchdog until their busy finally falls.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_off <= 2'b00;
    end else begin
      if (abort && !cur_side) hold_off[0] <= 1'b1;
      else if (!bus.buy_busy) hold_off[0] <= 1'b0;
      if (abort && cur_side)   hold_off[1] <= 1'b1;
      else if (!bus.sell_busy) hold_off[1] <= 1'b0;
    end
  end
`endif

  // Latches the popped entry onto the shared book buses; held until the next
  // issue because the book samples them on start_book.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cur_side <= 1'b0;
      req_q    <= '0;
      order_q  <= '0;
      id_q     <= '0;
      qty_q    <= '0;
    end else if (load) begin
      cur_side <= head.side;
      req_q    <= head.request;
      order_q  <= head.order;
      id_q     <= head.id;
      qty_q    <= head.qty;
    end
  end

  assign bus.buy_start    = (state == ISSUE) & ~cur_side;
  assign bus.sell_start   = (state == ISSUE) &  cur_side;
  assign bus.book_request = req_q;
  assign bus.book_order   = order_q;
  assign bus.book_id      = id_q;
  assign bus.book_qty     = qty_q;
  assign bus.done         = (state == DONE);
  assign bus.done_side    = (state == DONE) & cur_side;
  assign bus.err_invalid  = err_inv;
  assign bus.err_timeout  = err_to;
  assign bus.fifo_count   = count;

endmodule

`default_nettype wire

// File: tb/tb_order_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : tb_order_dispatcher
// Brief  : Directed self-checking bench for order_dispatcher with a simple
//          book model and a queue-based expectation of every issued message.
// Rev    : 1.0  initial release
// ============================================================================

`ifndef ORDER_INDEX
`define ORDER_INDEX 7
`endif
`ifndef QUANTITY_INDEX
`define QUANTITY_INDEX 15
`endif
`ifndef TOTAL_BITS
`define TOTAL_BITS 40
`endif
`ifndef ADD_ORDER
`define ADD_ORDER 3'b001
`endif
`ifndef CANCEL_ORDER
`define CANCEL_ORDER 3'b010
`endif
`ifndef EXECUTE_ORDER
`define EXECUTE_ORDER 3'b011
`endif

module tb_order_dispatcher;

  localparam int DEPTH  = 8;
  localparam int ACK_TO = 4;

  typedef struct packed {
    logic        side;
    logic [2:0]  req;
    logic [39:0] order;
    logic [7:0]  id;
    logic [15:0] qty;
  } msg_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  order_dispatcher_if #(.FIFO_DEPTH(DEPTH)) bus ();

  order_dispatcher #(
    .FIFO_DEPTH  (DEPTH),
    .ACK_TIMEOUT (ACK_TO),
    .BUSY_TIMEOUT(64)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Book model: raises busy the cycle after its start for len cycles
  // (len 0 = never answers); hold forces busy high independently.
  // --------------------------------------------------------------------------
  int   len0 = 3, len1 = 3;
  int   rem0 = 0, rem1 = 0;
  logic hold0 = 1'b0, hold1 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem0 <= 0;
      rem1 <= 0;
    end else begin
      if (bus.buy_start && len0 > 0) rem0 <= len0;
      else if (rem0 > 0)             rem0 <= rem0 - 1;
      if (bus.sell_start && len1 > 0) rem1 <= len1;
      else if (rem1 > 0)              rem1 <= rem1 - 1;
    end
  end

  assign bus.buy_busy  = (rem0 != 0) || hold0;
  assign bus.sell_busy = (rem1 != 0) || hold1;

  // --------------------------------------------------------------------------
  // Expectation model: accepted messages in arrival order; each start must
  // match the head, completion lands 2 cycles after the book's busy window
  // (start + len + 2), an unanswered start times out ACK_TO cycles later.
  // --------------------------------------------------------------------------
  msg_t        exp_q[$];
  msg_t        inf_e;
  logic        infl = 1'b0;
  int          st_cyc = 0, inf_len = 0;
  int          done_cnt = 0, inv_cnt = 0, to_cnt = 0;
  int          buy_starts = 0, sell_starts = 0;
  int          last_start_cyc = 0, last_done_cyc = 0, last_to_cyc = 0;
  logic [39:0] last_start_order = '0;
  logic [7:0]  last_start_id = '0;
  logic        exp_done, exp_to;

  function automatic logic is_valid(input logic [2:0] r);
    return (r == `ADD_ORDER) || (r == `CANCEL_ORDER) || (r == `EXECUTE_ORDER);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      infl = 1'b0;
    end else begin
      chk("both_starts", {63'd0, bus.buy_start & bus.sell_start}, 64'd0);
      if (bus.err_invalid) begin
        inv_cnt++;
        chk("invalid_head", {63'd0, (exp_q.size() > 0) && !is_valid(exp_q[0].req)}, 64'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.buy_start || bus.sell_start) begin
        chk("start_while_busy", {63'd0, infl}, 64'd0);
        chk("start_has_msg", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          inf_e            = exp_q.pop_front();
          chk("start_side", {63'd0, bus.sell_start}, {63'd0, inf_e.side});
          infl             = 1'b1;
          st_cyc           = cyc;
          inf_len          = inf_e.side ? len1 : len0;
          last_start_cyc   = cyc;
          last_start_order = bus.book_order;
          last_start_id    = bus.book_id;
          if (bus.sell_start) sell_starts++;
          else                buy_starts++;
        end
      end
      if (infl) begin
        chk("bus_request", {61'd0, bus.book_request}, {61'd0, inf_e.req});
        chk("bus_order",   {24'd0, bus.book_order},   {24'd0, inf_e.order});
        chk("bus_id",      {56'd0, bus.book_id},      {56'd0, inf_e.id});
        chk("bus_qty",     {48'd0, bus.book_qty},     {48'd0, inf_e.qty});
      end
      exp_done = infl && (inf_len > 0) && (cyc == st_cyc + inf_len + 2);
      exp_to   = infl && (inf_len == 0) && (cyc == st_cyc + ACK_TO);
      chk("done",        {63'd0, bus.done},        {63'd0, exp_done});
      chk("err_timeout", {63'd0, bus.err_timeout}, {63'd0, exp_to});
      if (exp_done) chk("done_side", {63'd0, bus.done_side}, {63'd0, inf_e.side});
      if (bus.done)        begin done_cnt++; last_done_cyc = cyc; end
      if (bus.err_timeout) begin to_cnt++;   last_to_cyc   = cyc; end
      if (exp_done || exp_to) infl = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  int acc_cyc = 0;

  task automatic push(input logic s, input logic [2:0] r, input logic [39:0] o,
                      input logic [7:0] i, input logic [15:0] q);
    int   g = 0;
    msg_t m;
    @(negedge clk);
    while (!bus.msg_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("push_ready", {63'd0, bus.msg_ready}, 64'd1);
    if (bus.msg_ready) begin
      bus.msg_valid   = 1'b1;
      bus.msg_side    = s;
      bus.msg_request = r;
      bus.msg_order   = o;
      bus.msg_id      = i;
      bus.msg_qty     = q;
      acc_cyc         = cyc;
      @(posedge clk);
      #1 bus.msg_valid = 1'b0;
      m.side = s; m.req = r; m.order = o; m.id = i; m.qty = q;
      exp_q.push_back(m);
    end
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    int g = 0;
    while (done_cnt < target && g < max_cyc) begin
      @(posedge clk);
      g++;
    end
    #2;
    chk("wait_done_bound", {63'd0, done_cnt >= target}, 64'd1);
  endtask

  task automatic wait_to(input int target, input int max_cyc);
    int g = 0;
    while (to_cnt < target && g < max_cyc) begin
      @(posedge clk);
      g++;
    end
    #2;
    chk("wait_timeout_bound", {63'd0, to_cnt >= target}, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int d0, s0, b0, i0, t0;

  initial begin
    bus.msg_valid   = 1'b0;
    bus.msg_side    = 1'b0;
    bus.msg_request = 3'd0;
    bus.msg_order   = '0;
    bus.msg_id      = '0;
    bus.msg_qty     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_count", {60'd0, bus.fifo_count}, 64'd0);
    chk("rst_ready",      {63'd0, bus.msg_ready}, 64'd0);
    chk("rst_buy_start",  {63'd0, bus.buy_start}, 64'd0);
    chk("rst_done",       {63'd0, bus.done},      64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_after_rst", {63'd0, bus.msg_ready}, 64'd1);

    // Add on buy side, busy for 3 cycles
    len0 = 3;
    push(1'b0, `ADD_ORDER, 40'h0064000501, 8'd1, 16'd5);
    wait_done(1, 50);
    chk("t1_start_latency", 64'(last_start_cyc), 64'(acc_cyc + 2));
    chk("t1_order",         {24'd0, last_start_order}, 64'h0064000501);
    chk("t1_done_cycle",    64'(last_done_cyc), 64'(last_start_cyc + 5));
    chk("t1_buy_starts",    64'(buy_starts),  64'd1);
    chk("t1_sell_starts",   64'(sell_starts), 64'd0);

    // Cancel id 7 on sell side while the sell book is busy
    hold1 = 1'b1;
    len1  = 2;
    s0    = sell_starts;
    push(1'b1, `CANCEL_ORDER, 40'h0, 8'd7, 16'd0);
    repeat (10) begin
      @(posedge clk);
      #2 chk("t2_no_start_while_busy", {63'd0, bus.sell_start}, 64'd0);
    end
    chk("t2_count_held", {60'd0, bus.fifo_count}, 64'd1);
    hold1 = 1'b0;
    wait_done(2, 50);
    chk("t2_one_start", 64'(sell_starts), 64'(s0 + 1));
    chk("t2_id",        {56'd0, last_start_id}, 64'd7);

    // Fill the FIFO against a stalled book, try a 9th, then drain in order
    hold0 = 1'b1;
    len0  = 2;
    for (int k = 0; k < 8; k++)
      push(1'b0, `EXECUTE_ORDER, 40'(k + 100), 8'(16 + k), 16'(k + 1));
    @(posedge clk);
    #2;
    chk("t3_count_full", {60'd0, bus.fifo_count}, 64'd8);
    chk("t3_ready_low",  {63'd0, bus.msg_ready},  64'd0);
    bus.msg_valid   = 1'b1;
    bus.msg_side    = 1'b0;
    bus.msg_request = `ADD_ORDER;
    bus.msg_id      = 8'd99;
    repeat (3) begin
      @(posedge clk);
      #2 chk("t3_no_push_when_full", {60'd0, bus.fifo_count}, 64'd8);
    end
    bus.msg_valid = 1'b0;
    d0    = done_cnt;
    hold0 = 1'b0;
    wait_done(d0 + 8, 200);
    chk("t3_done_count", 64'(done_cnt - d0), 64'd8);
    chk("t3_drained",    {60'd0, bus.fifo_count}, 64'd0);

    // Unknown request code is dropped
    i0 = inv_cnt;
    b0 = buy_starts;
    s0 = sell_starts;
    push(1'b0, 3'b111, 40'h1234, 8'd9, 16'd9);
    repeat (4) @(posedge clk);
    #2;
    chk("t4_err_invalid", 64'(inv_cnt), 64'(i0 + 1));
    chk("t4_no_start",    64'(buy_starts + sell_starts), 64'(b0 + s0));
    chk("t4_count_zero",  {60'd0, bus.fifo_count}, 64'd0);

    // Book never acknowledges, then a normal message recovers
    len0 = 0;
    t0   = to_cnt;
    d0   = done_cnt;
    push(1'b0, `ADD_ORDER, 40'h00AA, 8'd3, 16'd4);
    wait_to(t0 + 1, 40);
    chk("t5_timeout_cycle", 64'(last_to_cyc), 64'(last_start_cyc + 4));
    chk("t5_no_done",       64'(done_cnt), 64'(d0));
    len0 = 2;
    push(1'b0, `ADD_ORDER, 40'h00BB, 8'd4, 16'd6);
    wait_done(d0 + 1, 40);
    chk("t5_recover_done",  64'(last_done_cyc), 64'(last_start_cyc + 4));

    // Reset asserted in WAIT_DONE with a second message still queued
    len0 = 20;
    push(1'b0, `ADD_ORDER, 40'h0000000501, 8'd5, 16'd1);
    push(1'b0, `ADD_ORDER, 40'h0000000601, 8'd6, 16'd2);
    repeat (4) @(posedge clk);
    #2;
    chk("t6_in_flight_id", {56'd0, bus.book_id},    64'd5);
    chk("t6_queued",       {60'd0, bus.fifo_count}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count",    {60'd0, bus.fifo_count}, 64'd0);
    chk("t6_rst_id",       {56'd0, bus.book_id},    64'd0);
    chk("t6_rst_order",    {24'd0, bus.book_order}, 64'd0);
    chk("t6_rst_done",     {63'd0, bus.done},       64'd0);
    chk("t6_rst_start",    {63'd0, bus.buy_start | bus.sell_start}, 64'd0);
    chk("t6_rst_ready",    {63'd0, bus.msg_ready},  64'd0);
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("t6_no_done",      64'(done_cnt), 64'(d0));
    chk("t6_count_after",  {60'd0, bus.fifo_count}, 64'd0);
    chk("t6_ready_after",  {63'd0, bus.msg_ready},  64'd1);
    len0 = 1;
    push(1'b0, `EXECUTE_ORDER, 40'h0000000777, 8'd8, 16'd3);
    wait_done(d0 + 1, 40);
    chk("t6_post_reset_id", {56'd0, last_start_id}, 64'd8);
    chk("model_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
